// File: rtl/sn_tone_period_detector_if.sv
// -----------------------------------------------------------------------------
// sn_tone_period_detector_if
// Bundles the sample strobe, arm requests, packed channel samples and the
// per-channel measurement results of the tone period detector.
//   master : drives clock_en_i, arm_i, sample_i; observes the results
//   slave  : the detector itself
// Signals:
//   clock_en_i   sample strobe
//   arm_i        per-channel arm/restart request (NUM_CH)
//   sample_i     packed samples, channel 0 in the lowest slice
//   counter_o    measured (averaged) period per channel, in strobe ticks
//   magnitude_o  peak sample over the measured window per channel
//   done_o       measurement complete per channel
//   timeout_o    measurement ended by accumulator saturation per channel
//   busy_o       channel waiting for an opening edge or measuring
// -----------------------------------------------------------------------------
interface sn_tone_period_detector_if #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 8,
  parameter int CNT_W    = 10
);
  logic                         clock_en_i;
  logic [NUM_CH-1:0]            arm_i;
  logic [NUM_CH*SAMPLE_W-1:0]   sample_i;
  logic [NUM_CH*CNT_W-1:0]      counter_o;
  logic [NUM_CH*SAMPLE_W-1:0]   magnitude_o;
  logic [NUM_CH-1:0]            done_o;
  logic [NUM_CH-1:0]            timeout_o;
  logic [NUM_CH-1:0]            busy_o;

  modport master (
    output clock_en_i, arm_i, sample_i,
    input  counter_o, magnitude_o, done_o, timeout_o, busy_o
  );

  modport slave (
    input  clock_en_i, arm_i, sample_i,
    output counter_o, magnitude_o, done_o, timeout_o, busy_o
  );
endinterface

// File: rtl/sn_tone_period_detector.sv
// -----------------------------------------------------------------------------
// sn_tone_period_detector
// Multi-channel rising-edge period and peak-magnitude detector for the sound
// generator outputs. Each channel waits for an opening rising edge, then counts
// strobe ticks over 2^PERIODS_LOG2 periods and reports the averaged period and
// the peak sample seen. A measurement that never closes ends when the tick
// accumulator saturates and is flagged as a timeout.
// Ports:
//   clk    system clock
//   res_i  synchronous active-high reset
//   bus    slave side of sn_tone_period_detector_if (strobe, arm, samples in;
//          counter, magnitude, done, timeout, busy out)
// -----------------------------------------------------------------------------
module sn_tone_period_detector #(
  parameter int NUM_CH       = 4,
  parameter int SAMPLE_W     = 8,
  parameter int CNT_W        = 10,
  parameter int PERIODS_LOG2 = 0,
  parameter int THRESH       = 0
) (
  input  logic                        clk,
  input  logic                        res_i,
  sn_tone_period_detector_if.slave    bus
);

  localparam int AW = CNT_W + PERIODS_LOG2;
  localparam int PW = PERIODS_LOG2 + 1;
  localparam logic [PW-1:0]       PCNT_LAST = PW'(1) << PERIODS_LOG2;
  localparam logic [SAMPLE_W-1:0] THRESH_V  = SAMPLE_W'(THRESH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SYNC    = 2'd1,
    S_MEASURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  function automatic logic [SAMPLE_W-1:0] peak_max(
    input logic [SAMPLE_W-1:0] a,
    input logic [SAMPLE_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    state_t              r_state, w_state_nxt;
    logic                r_prev_high, w_prev_high_nxt;
    logic [AW-1:0]       r_acc, w_acc_nxt;
    logic [PW-1:0]       r_pcnt, w_pcnt_nxt;
    logic [SAMPLE_W-1:0] r_pk, w_pk_nxt;
    logic [CNT_W-1:0]    r_counter, w_counter_nxt;
    logic [SAMPLE_W-1:0] r_mag, w_mag_nxt;
    logic                r_done, w_done_nxt;
    logic                r_timeout, w_timeout_nxt;
    logic                r_busy;

    logic [SAMPLE_W-1:0] w_sample;
    logic                w_high;
    logic                w_rise;
    logic                w_arm;
    logic [AW-1:0]       w_acc_inc;
    logic [PW-1:0]       w_pcnt_inc;
    logic [SAMPLE_W-1:0] w_pk_max;

    assign w_sample   = bus.sample_i[ch*SAMPLE_W +: SAMPLE_W];
    assign w_high     = (w_sample > THRESH_V);
    assign w_rise     = bus.clock_en_i & w_high & ~r_prev_high;
    assign w_arm      = bus.arm_i[ch];
    assign w_acc_inc  = r_acc + 1'b1;
    assign w_pcnt_inc = r_pcnt + 1'b1;
    assign w_pk_max   = peak_max(r_pk, w_sample);

    always_comb begin
      w_state_nxt     = r_state;
      w_prev_high_nxt = r_prev_high;
      w_acc_nxt       = r_acc;
      w_pcnt_nxt      = r_pcnt;
      w_pk_nxt        = r_pk;
      w_counter_nxt   = r_counter;
      w_mag_nxt       = r_mag;
      w_done_nxt      = r_done;
      w_timeout_nxt   = r_timeout;

      // Edge history tracks every strobe, even in the arm cycle.
      if (bus.clock_en_i) begin
        w_prev_high_nxt = w_high;
      end

      // Arm restarts from any state and is accepted without a strobe; the
      // arm-cycle sample is never taken as an opening edge.
      if (w_arm) begin
        w_state_nxt   = S_SYNC;
        w_done_nxt    = 1'b0;
        w_timeout_nxt = 1'b0;
        w_acc_nxt     = '0;
        w_pcnt_nxt    = '0;
        w_pk_nxt      = '0;
      end else if (bus.clock_en_i) begin
        unique case (r_state)
          S_SYNC: begin
            if (w_rise) begin
              w_state_nxt = S_MEASURE;
              w_acc_nxt   = '0;
              w_pcnt_nxt  = '0;
              w_pk_nxt    = w_sample;
            end
          end
          S_MEASURE: begin
            // A closing edge wins over saturation on the same tick.
            if (w_rise && (w_pcnt_inc == PCNT_LAST)) begin
              w_state_nxt   = S_DONE;
              w_counter_nxt = w_acc_inc[AW-1:PERIODS_LOG2];
              w_mag_nxt     = w_pk_max;
              w_done_nxt    = 1'b1;
            end else if (w_acc_inc == '1) begin
              w_state_nxt   = S_DONE;
              w_counter_nxt = '1;
              w_mag_nxt     = r_pk;
              w_done_nxt    = 1'b1;
              w_timeout_nxt = 1'b1;
            end else begin
              w_acc_nxt = w_acc_inc;
              w_pk_nxt  = w_pk_max;
              if (w_rise) begin
                w_pcnt_nxt = w_pcnt_inc;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (res_i) begin
        r_state     <= S_IDLE;
        r_prev_high <= 1'b0;
        r_acc       <= '0;
        r_pcnt      <= '0;
        r_pk        <= '0;
        r_counter   <= '0;
        r_mag       <= '0;
        r_done      <= 1'b0;
        r_timeout   <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        r_state     <= w_state_nxt;
        r_prev_high <= w_prev_high_nxt;
        r_acc       <= w_acc_nxt;
        r_pcnt      <= w_pcnt_nxt;
        r_pk        <= w_pk_nxt;
        r_counter   <= w_counter_nxt;
        r_mag       <= w_mag_nxt;
        r_done      <= w_done_nxt;
        r_timeout   <= w_timeout_nxt;
        r_busy      <= (w_state_nxt == S_SYNC) || (w_state_nxt == S_MEASURE);
      end
    end

    assign bus.counter_o[ch*CNT_W +: CNT_W]         = r_counter;
    assign bus.magnitude_o[ch*SAMPLE_W +: SAMPLE_W] = r_mag;
    assign bus.done_o[ch]                           = r_done;
    assign bus.timeout_o[ch]                        = r_timeout;
    assign bus.busy_o[ch]                           = r_busy;
  end

endmodule
